// File: rtl/rv32_imm_encoder_if.sv
// Request/response bundle for the RV32 immediate encoder.
// Valid/ready on both the request and the output word side.
interface rv32_imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [31:0] in_instr;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic        out_last;

  modport master (
    output in_valid, in_fmt, in_instr, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_err, out_last
  );

  modport slave (
    input  in_valid, in_fmt, in_instr, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_err, out_last
  );
endinterface

// File: rtl/rv32_imm_encoder.sv
// Packs immediates into RV32 instruction templates, range-checks them,
// and expands LI into one or two words (LUI+ADDI).
module rv32_imm_encoder #(
  parameter bit CHECK_RANGE = 1'b1,
  parameter bit LI_SHORTEN  = 1'b1
) (
  input logic clk,
  input logic reset_n,
  rv32_imm_encoder_if.slave bus
);
  localparam logic [2:0] F_I  = 3'd0;
  localparam logic [2:0] F_S  = 3'd1;
  localparam logic [2:0] F_B  = 3'd2;
  localparam logic [2:0] F_U  = 3'd3;
  localparam logic [2:0] F_J  = 3'd4;
  localparam logic [2:0] F_SH = 3'd5;
  localparam logic [2:0] F_Z  = 3'd6;
  localparam logic [6:0] OP_LUI = 7'h37;
  localparam logic [6:0] OP_IMM = 7'h13;

  typedef enum logic {IDLE, LI_SECOND} state_t;

  state_t      state_q, state_d;
  logic [31:0] second_q;
  logic [31:0] imm, tmpl;
  logic        adv, accept;
  logic        ok11, ok12, ok20;
  logic [4:0]  rd;
  logic [11:0] lo;
  logic [19:0] hi;
  logic [31:0] w_lui, w_addi0, w_addi;
  logic [31:0] enc_instr;
  logic        enc_err, enc_last, two;

  assign imm  = bus.in_imm;
  assign tmpl = bus.in_instr;

  assign adv         = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = (state_q == IDLE) && adv;
  assign accept      = bus.in_valid && bus.in_ready;

  assign ok11 = (&imm[31:11]) | ~(|imm[31:11]);
  assign ok12 = (&imm[31:12]) | ~(|imm[31:12]);
  assign ok20 = (&imm[31:20]) | ~(|imm[31:20]);

  // hi rounds up when lo is negative so ADDI's sign extension cancels out
  assign rd      = tmpl[11:7];
  assign lo      = imm[11:0];
  assign hi      = imm[31:12] + {19'd0, imm[11]};
  assign w_lui   = {hi, rd, OP_LUI};
  assign w_addi0 = {lo, 5'd0, 3'b000, rd, OP_IMM};
  assign w_addi  = {lo, rd, 3'b000, rd, OP_IMM};

  always_comb begin
    enc_instr = tmpl;
    enc_err   = 1'b0;
    enc_last  = 1'b1;
    two       = 1'b0;
    unique case (bus.in_fmt)
      F_I: begin
        enc_instr = {imm[11:0], tmpl[19:0]};
        enc_err   = !ok11;
      end
      F_S: begin
        enc_instr = {imm[11:5], tmpl[24:12], imm[4:0], tmpl[6:0]};
        enc_err   = !ok11;
      end
      F_B: begin
        enc_instr = {imm[12], imm[10:5], tmpl[24:12],
                     imm[4:1], imm[11], tmpl[6:0]};
        enc_err   = !ok12 || imm[0];
      end
      F_U: begin
        enc_instr = {imm[31:12], tmpl[11:0]};
        enc_err   = |imm[11:0];
      end
      F_J: begin
        enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], tmpl[11:0]};
        enc_err   = !ok20 || imm[0];
      end
      F_SH: begin
        enc_instr = {tmpl[31:25], imm[4:0], tmpl[19:0]};
        enc_err   = |imm[31:5];
      end
      F_Z: begin
        enc_instr = {tmpl[31:20], imm[4:0], tmpl[14:0]};
        enc_err   = |imm[31:5];
      end
      default: begin
        if (LI_SHORTEN && ok11) begin
          enc_instr = w_addi0;
        end else if (LI_SHORTEN && lo == 12'd0) begin
          enc_instr = w_lui;
        end else begin
          enc_instr = w_lui;
          enc_last  = 1'b0;
          two       = 1'b1;
        end
      end
    endcase
    if (!CHECK_RANGE) enc_err = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (accept && two) state_d = LI_SECOND;
      LI_SECOND: if (adv) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      second_q      <= 32'd0;
      bus.out_valid <= 1'b0;
      bus.out_instr <= 32'd0;
      bus.out_err   <= 1'b0;
      bus.out_last  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) second_q <= w_addi;
      if (adv) begin
        if (state_q == LI_SECOND) begin
          bus.out_valid <= 1'b1;
          bus.out_instr <= second_q;
          bus.out_err   <= 1'b0;
          bus.out_last  <= 1'b1;
        end else if (accept) begin
          bus.out_valid <= 1'b1;
          bus.out_instr <= enc_instr;
          bus.out_err   <= enc_err;
          bus.out_last  <= enc_last;
        end else begin
          bus.out_valid <= 1'b0;
        end
      end
    end
  end
endmodule
